// File: rtl/dmem_ctrl_pkg.sv
// Shared constants, state encoding and alignment helper for the data-memory controller.
package dmem_ctrl_pkg;

    localparam logic [1:0] DSIZE_BYTE = 2'b00;
    localparam logic [1:0] DSIZE_HALF = 2'b01;
    localparam logic [1:0] DSIZE_WORD = 2'b10;
    localparam logic [1:0] DSIZE_BAD  = 2'b11;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        DMEM_IDLE = 2'd0,
        DMEM_WAIT = 2'd1,
        DMEM_DONE = 2'd2
    } dmem_state_e;

    // Halves must sit on even bytes, words on multiples of four.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        logic bad;
        bad = 1'b0;
        if (size == DSIZE_HALF) bad = off[0];
        if (size == DSIZE_WORD) bad = (off != 2'b00);
        return bad;
    endfunction

endpackage

// File: rtl/dmem_ctrl_align.sv
// Big-endian lane steering: store byte-enables/write word and load extraction/extension.
module dmem_align
    import dmem_ctrl_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_offset,
    input  logic [31:0] i_wr_data,
    input  logic [31:0] i_raw_word,
    input  logic        i_signed,
    output logic [3:0]  o_byte_en,
    output logic [31:0] o_wr_word,
    output logic [31:0] o_rd_data,
    output logic        o_misalign
);

    function automatic logic [3:0] store_be(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] be;
        logic [3:0] one_lane;
        be       = 4'b0000;
        one_lane = 4'b1000;
        case (size)
            DSIZE_BYTE: be = one_lane >> off;
            DSIZE_HALF: be = off[1] ? 4'b0011 : 4'b1100;
            DSIZE_WORD: be = 4'b1111;
            default:    be = 4'b0000;
        endcase
        return be;
    endfunction

    // Offset 0 is the most significant lane, so shifting left by the offset
    // brings the addressed byte/half to the top of the word.
    function automatic logic [31:0] load_extract(input logic [31:0] raw, input logic [1:0] size,
                                                 input logic [1:0] off, input logic sgn);
        logic [31:0] shifted;
        logic [31:0] res;
        shifted = raw << {off, 3'b000};
        case (size)
            DSIZE_BYTE: res = {{24{sgn & shifted[31]}}, shifted[31:24]};
            DSIZE_HALF: res = {{16{sgn & shifted[31]}}, shifted[31:16]};
            default:    res = raw;
        endcase
        return res;
    endfunction

    always_comb begin
        o_byte_en  = store_be(i_size, i_offset);
        o_rd_data  = load_extract(i_raw_word, i_size, i_offset, i_signed);
        o_misalign = is_misaligned(i_size, i_offset);
        o_wr_word  = i_wr_data;
        case (i_size)
            DSIZE_BYTE: o_wr_word = {4{i_wr_data[7:0]}};
            DSIZE_HALF: o_wr_word = {2{i_wr_data[15:0]}};
            default:    o_wr_word = i_wr_data;
        endcase
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Multi-cycle DMEM responder: latches a request, waits LAT cycles, then performs
// the access against a byte-lane RAM and releases the pipeline for one cycle.
module dmem_ctrl
    import dmem_ctrl_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = 10,
    parameter int LAT   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] memAddr,
    input  logic [31:0] memWrData,
    input  logic [1:0]  dSize,
    input  logic        memWr,
    input  logic        memRd,
    input  logic        memSigned,
    output logic [31:0] memRdData,
    output logic        memStall,
    output logic        memErr
);

    dmem_state_e      r_state;
    dmem_state_e      w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [AW-1:0]    r_idx;
    logic [1:0]       r_off;
    logic [31:0]      r_wdata;
    logic [1:0]       r_size;
    logic             r_wr;
    logic             r_rd;
    logic             r_signed;
    logic [31:0]      r_rd_data;
    logic             r_err;

    logic             w_req;
    logic             w_stall;
    logic             w_access;
    logic             w_illegal;
    logic             w_misalign;
    logic             w_mem_we;
    logic [3:0]       w_be;
    logic [31:0]      w_wr_word;
    logic [31:0]      w_ld_data;
    logic [31:0]      w_rd_word;
    logic [AW-1:0]    w_rd_idx;
    logic             w_unused_addr;

    // Upper address bits are intentionally dropped so the array wraps.
    assign w_unused_addr = ^memAddr[31:AW+2];

    assign w_req     = memRd | memWr;
    assign w_access  = (r_state == DMEM_WAIT) && (r_cnt == '0);
    assign w_illegal = (r_size == DSIZE_BAD) | w_misalign | (r_rd & r_wr);
    assign w_mem_we  = w_access & r_wr & ~w_illegal;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= DMEM_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_stall      = 1'b0;
        case (r_state)
            DMEM_IDLE: begin
                if (w_req) begin
                    w_stall      = 1'b1;
                    w_state_next = DMEM_WAIT;
                end
            end
            DMEM_WAIT: begin
                w_stall = 1'b1;
                if (r_cnt == '0) w_state_next = DMEM_DONE;
            end
            DMEM_DONE: w_state_next = DMEM_IDLE;
            default:   w_state_next = DMEM_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= '0;
            r_idx     <= '0;
            r_off     <= 2'b00;
            r_wdata   <= '0;
            r_size    <= DSIZE_BYTE;
            r_wr      <= 1'b0;
            r_rd      <= 1'b0;
            r_signed  <= 1'b0;
            r_rd_data <= '0;
            r_err     <= 1'b0;
        end else begin
            r_err <= 1'b0;
            if (r_state == DMEM_IDLE && w_req) begin
                r_cnt    <= CNT_W'(LAT - 1);
                r_idx    <= memAddr[AW+1:2];
                r_off    <= memAddr[1:0];
                r_wdata  <= memWrData;
                r_size   <= dSize;
                r_wr     <= memWr;
                r_rd     <= memRd;
                r_signed <= memSigned;
            end else if (r_state == DMEM_WAIT && r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (w_access) begin
                r_err <= w_illegal;
                if (r_rd && !w_illegal) r_rd_data <= w_ld_data;
            end
        end
    end

    // The read address tracks the incoming request while idle, so the
    // registered read word is ready even when LAT is 1.
    assign w_rd_idx = (r_state == DMEM_IDLE) ? memAddr[AW+1:2] : r_idx;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] r_mem [DEPTH];
            logic [7:0] r_lane_q;

            always_ff @(posedge clk) begin
                if (w_mem_we && w_be[gi]) r_mem[r_idx] <= w_wr_word[8*gi +: 8];
                r_lane_q <= r_mem[w_rd_idx];
            end

            assign w_rd_word[8*gi +: 8] = r_lane_q;
        end
    endgenerate

    dmem_align u_align (
        .i_size     (r_size),
        .i_offset   (r_off),
        .i_wr_data  (r_wdata),
        .i_raw_word (w_rd_word),
        .i_signed   (r_signed),
        .o_byte_en  (w_be),
        .o_wr_word  (w_wr_word),
        .o_rd_data  (w_ld_data),
        .o_misalign (w_misalign)
    );

    assign memRdData = r_rd_data;
    assign memStall  = w_stall;
    assign memErr    = r_err;

endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
Data-memory responder for the pipeline's DMEM interface. It accepts the pipeline's load and store requests (address, write data, size, direction) and services them against an internal word-organised array with configurable access latency. It stalls the pipeline while an access is pending and returns size-aligned, optionally sign-extended load data. It sits at the top level beside the pipeline and replaces the zero-latency behavioural DMEM.

Parameters:
DEPTH, 1024, number of 32-bit words in the array; power of two
AW, 10, word-index width, log2(DEPTH)
LAT, 2, wait cycles per access; legal range 1..15

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-high
memAddr  input  32  byte address from pipeline
memWrData  input  32  store data, right-justified (byte in [7:0], half in [15:0])
dSize  input  2  access size: byte, half or word
memWr  input  1  store request
memRd  input  1  load request
memSigned  input  1  sign-extend loaded byte or half when 1, zero-extend when 0
memRdData  output  32  load result, right-justified and extended
memStall  output  1  pipeline must hold its MEM stage while high
memErr  output  1  one-cycle pulse flagging an illegal request

Behaviour:
- Endianness is big-endian. Byte offset 0 maps to word bits [31:24]. Half offset 0 maps to [31:16].
- Word index is memAddr[AW+1:2]. Upper address bits are ignored, so addresses wrap modulo DEPTH*4.
- The controller has three states: IDLE, WAIT and DONE. The state encoding is shared.
- In IDLE, a request is memRd or memWr high. On a request:
  - memStall goes high combinationally in that same cycle.
  - memAddr, memWrData, dSize, memWr, memRd and memSigned are latched.
  - The counter loads LAT-1 and the state moves to WAIT.
- In WAIT, memStall is 1 and the counter decrements each cycle.
  - At the edge where the counter is 0, the access is performed and the state moves to DONE.
  - A store updates only the addressed byte lanes; the other lanes are preserved.
  - A load registers the extracted and extended value into memRdData.
- In DONE, memStall is 0 for exactly one cycle so the pipeline advances. The state then returns to IDLE unconditionally. Any request present during DONE is not sampled there; it is taken in the following IDLE cycle.
- Total stall per access is LAT+1 cycles. Data is valid in the DONE cycle and stays held until the next load completes.
- memRdData changes only at load completion or reset. Stores and errors leave it unchanged.
- A request is illegal when any of the following holds:
  - dSize is 2'b11;
  - a half access has memAddr[0]=1;
  - a word access has memAddr[1:0] not equal to 0;
  - memRd and memWr are both high.
- An illegal request still walks IDLE, WAIT, DONE with the same timing. No array write occurs and memRdData is not updated. memErr is 1 in the DONE cycle only.
- In IDLE with no request, memStall is 0.
- Reset values: state IDLE, counter 0, memRdData 0, memStall 0, memErr 0. Array contents are not reset.
- Reset asserted mid-access returns to IDLE immediately. A pending store is dropped and the array is untouched.
- Request inputs are not required to stay stable after the IDLE capture cycle; latched copies are used.

Decomposition:
- constants.vh: DSIZE_BYTE=2'b00, DSIZE_HALF=2'b01, DSIZE_WORD=2'b10; DMEM_IDLE/DMEM_WAIT/DMEM_DONE state codes.
- Sub-module dmem_align (combinational), with two functions:
  - Store path: builds the 4-bit byte-enable and the lane-shifted write word from size, offset and data.
  - Load path: extracts and extends the read result from the raw word, size, offset and signed flag.
  - It also produces the misalignment flag.
- dmem_ctrl holds the FSM, counter, latched request, array and output registers.

Test Plan:
- LAT=2, word store 0xDEADBEEF to 0x40, then a word load of 0x40 -> memStall high 3 cycles per access; memRdData=0xDEADBEEF in the DONE cycle; memErr=0.
- Word 0x11223344 at 0x80, then byte store 0xAA to 0x81 and a word load of 0x80 -> 0x11AA3344.
- Word 0x80FF7F01 at 0x100; load byte 0x100 with signed=1 -> 0xFFFFFF80. Same with signed=0 -> 0x00000080. Half at 0x102, signed=1 -> 0x00007F01.
- Half store to 0x43, word load of 0x42, and dSize=2'b11 -> each gives memErr=1 for one DONE cycle; array and memRdData unchanged; the pipeline is still released after LAT+1 stall cycles.
- Store 0x12345678 to 0x0 and to 0x0+DEPTH*4 (wraps), then load 0x0 -> second value returned; confirms address wrap.
- Assert rst during WAIT of a store of 0xCAFEF00D to 0x20 -> memStall=0 immediately; a later load of 0x20 returns the prior contents.
